handshake_const_check: RTL and testbench

- Dataflow endpoint that consumes a data token and emits a dataless control token. This is the reverse direction of the constant generator, which turns a control token into data.
- Each consumed token is compared against a compile-time EXPECTED constant. The result bit travels with the control token.
- Match and mismatch counts plus a sticky error flag are kept for debug and verification.
- Input ready is fully registered through a 2-entry skid buffer, so the block breaks the ready timing path between its producer and consumer.

---
 rtl/handshake_const_check.sv | 137 +++++++++++++
 tb/tb_handshake_const_check.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/handshake_const_check.sv
// handshake_const_check: dataflow sink that compares each data token against
// a constant and turns it into a dataless control token that carries the
// result as a match bit. Input ready is registered, and a two-slot skid buffer
// (MAIN + SKID) keeps full throughput despite that.
// Optional build macro HANDSHAKE_CONST_CHECK_MASK_EN: when it is defined, only
// the bits set in MASK take part in the comparison.
module handshake_const_check #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  EXPECTED   = '0,
  parameter logic [DATA_WIDTH-1:0]  MASK       = '1,
  parameter int unsigned            CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  outs_match,
  output logic [DATA_WIDTH-1:0] last_value,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  err
);

  // The occupancy of the buffer is the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Each slot holds the token together with its precomputed match bit.
  typedef struct packed {
    logic                  match;
    logic [DATA_WIDTH-1:0] data;
  } slot_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t state_q, state_d;
  slot_t  main_q, main_d;
  slot_t  skid_q, skid_d;
  slot_t  in_slot;
  logic   in_match;
  logic   in_fire;
  logic   out_fire;

  // The compare is done once, at acceptance, so the output side only reads
  // a stored bit and adds no logic depth after the buffer.
`ifdef HANDSHAKE_CONST_CHECK_MASK_EN
  assign in_match = (((ins ^ EXPECTED) & MASK) == '0);
`else
  logic unused_mask;
  assign unused_mask = ^MASK;
  assign in_match    = (ins == EXPECTED);
`endif

  assign in_slot    = '{match: in_match, data: ins};
  assign outs_valid = (state_q != EMPTY);
  assign outs_match = main_q.match;
  assign in_fire    = ins_valid & ins_ready;
  assign out_fire   = outs_valid & outs_ready;

  // Next state and slot routing. MAIN always holds the oldest token.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_slot;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_slot;
        end else if (in_fire) begin
          skid_d  = in_slot;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // ins_ready is low in FULL, so only the drain case exists here.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and slot registers. Reset drops any buffered token.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Registered ready: it follows the next state, so it is low exactly while
  // the buffer is FULL and it never depends combinationally on an input.
  always_ff @(posedge clk) begin
    if (rst) ins_ready <= 1'b0;
    else     ins_ready <= (state_d != FULL);
  end

  // Debug statistics, updated on every output transfer; the counters saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_value     <= '0;
      match_count    <= '0;
      mismatch_count <= '0;
      err            <= 1'b0;
    end else if (out_fire) begin
      last_value <= main_q.data;
      if (main_q.match) begin
        if (match_count != CNT_MAX) match_count <= match_count + 1'b1;
      end else begin
        if (mismatch_count != CNT_MAX) mismatch_count <= mismatch_count + 1'b1;
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_handshake_const_check.sv
// Bench for handshake_const_check (DATA_WIDTH=6, EXPECTED=28, CNT_WIDTH=2).
// A per-cycle vector table covers reset, streaming, backpressure, saturation,
// mid-run reset and mask cases. An independent scoreboard checks every cycle,
// and a random phase with a bounded drain follows the table.
module tb_handshake_const_check;

  localparam int DW = 6;
  localparam int CW = 2;
  localparam logic [DW-1:0] EXP_C  = 6'b011100;
  localparam logic [DW-1:0] MASK_C = 6'b111000;
`ifdef HANDSHAKE_CONST_CHECK_MASK_EN
  localparam bit MK = 1'b1;
`else
  localparam bit MK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] ins = '0;
  logic          ins_valid = 1'b0;
  logic          ins_ready;
  logic          outs_valid;
  logic          outs_ready = 1'b0;
  logic          outs_match;
  logic [DW-1:0] last_value;
  logic [CW-1:0] match_count;
  logic [CW-1:0] mismatch_count;
  logic          err;

  handshake_const_check #(
    .DATA_WIDTH(DW), .EXPECTED(EXP_C), .MASK(MASK_C), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs_valid(outs_valid), .outs_ready(outs_ready), .outs_match(outs_match),
    .last_value(last_value), .match_count(match_count),
    .mismatch_count(mismatch_count), .err(err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input int idx, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0d: got %0d, expected %0d", nm, idx, act, exp);
  endtask

  function automatic bit ref_match(input logic [DW-1:0] d);
    if (MK) return (((d ^ EXP_C) & MASK_C) == '0);
    else    return (d == EXP_C);
  endfunction

  // Scoreboard: tokens are pushed on acceptance and popped on delivery.
  typedef struct {
    logic [DW-1:0] d;
    bit            m;
  } tok_t;
  tok_t          q[$];
  bit            started = 1'b0;
  bit            e_rdy   = 1'b0;
  bit            e_err   = 1'b0;
  int            e_mc    = 0;
  int            e_mmc   = 0;
  logic [DW-1:0] e_last  = '0;
  int            cyc     = 0;

  always @(negedge clk) begin
    bit   of, inf;
    tok_t t;
    cyc++;
    if (started) begin
      chk("sb_ins_ready", cyc, ins_ready, e_rdy);
      chk("sb_outs_valid", cyc, outs_valid, q.size() != 0);
      if (q.size() != 0) chk("sb_outs_match", cyc, outs_match, q[0].m);
      chk("sb_match_count", cyc, match_count, e_mc);
      chk("sb_mismatch_count", cyc, mismatch_count, e_mmc);
      chk("sb_err", cyc, err, e_err);
      chk("sb_last_value", cyc, last_value, e_last);
    end
    if (rst) begin
      q.delete();
      e_rdy = 0; e_err = 0; e_mc = 0; e_mmc = 0; e_last = '0;
      started = 1'b1;
    end else if (started) begin
      of  = (q.size() != 0) && outs_ready;
      inf = e_rdy && ins_valid;
      if (of) begin
        t = q.pop_front();
        e_last = t.d;
        if (t.m) begin
          if (e_mc != 3) e_mc++;
        end else begin
          if (e_mmc != 3) e_mmc++;
          e_err = 1'b1;
        end
      end
      if (inf) q.push_back('{d: ins, m: ref_match(ins)});
      e_rdy = (q.size() != 2);
    end
  end

  // The expected columns give the outputs after the edge that consumed the
  // previous row's inputs.
  typedef struct {
    bit            rst, iv;
    logic [DW-1:0] d;
    bit            ordy;
    bit            e_rdy, e_ov, e_om;
    int            e_mc, e_mmc;
    bit            e_err;
    logic [DW-1:0] e_last;
  } vec_t;
  vec_t tbl[28];

  initial begin
    // reset held 3 cycles with a valid matching token on the input
    tbl[0]  = '{1,1,28,0, 0,0,0, 0,0,0, 0};
    tbl[1]  = '{1,1,28,0, 0,0,0, 0,0,0, 0};
    tbl[2]  = '{1,1,28,0, 0,0,0, 0,0,0, 0};
    tbl[3]  = '{0,0, 0,1, 0,0,0, 0,0,0, 0};
    // streaming 28, 28, 5
    tbl[4]  = '{0,1,28,1, 1,0,0, 0,0,0, 0};
    tbl[5]  = '{0,1,28,1, 1,1,1, 0,0,0, 0};
    tbl[6]  = '{0,1, 5,1, 1,1,1, 1,0,0, 28};
    tbl[7]  = '{0,0, 0,1, 1,1,0, 2,0,0, 28};
    tbl[8]  = '{1,0, 0,0, 1,0,0, 2,1,1, 5};
    // backpressure 28, 28, 28
    tbl[9]  = '{0,1,28,0, 0,0,0, 0,0,0, 0};
    tbl[10] = '{0,1,28,0, 1,0,0, 0,0,0, 0};
    tbl[11] = '{0,1,28,0, 1,1,1, 0,0,0, 0};
    tbl[12] = '{0,1,28,0, 0,1,1, 0,0,0, 0};
    tbl[13] = '{0,1,28,0, 0,1,1, 0,0,0, 0};
    tbl[14] = '{0,1,28,1, 0,1,1, 0,0,0, 0};
    tbl[15] = '{0,1,28,1, 1,1,1, 1,0,0, 28};
    tbl[16] = '{0,0, 0,1, 1,1,1, 2,0,0, 28};
    // two more matches: five since reset, match_count saturates at 3
    tbl[17] = '{0,1,28,1, 1,0,0, 3,0,0, 28};
    tbl[18] = '{0,1,28,1, 1,1,1, 3,0,0, 28};
    tbl[19] = '{0,0, 0,1, 1,1,1, 3,0,0, 28};
    // fill to FULL, then a 1-cycle reset
    tbl[20] = '{0,1,28,0, 1,0,0, 3,0,0, 28};
    tbl[21] = '{0,1, 5,0, 1,1,1, 3,0,0, 28};
    tbl[22] = '{1,0, 0,1, 0,1,1, 3,0,0, 28};
    tbl[23] = '{0,0, 0,1, 0,0,0, 0,0,0, 0};
    // masked compare: 6'b011111
    tbl[24] = '{0,1,31,0, 1,0,0, 0,0,0, 0};
    tbl[25] = '{0,0, 0,1, 1,1,MK, 0,0,0, 0};
    tbl[26] = '{0,0, 0,0, 1,0,0, int'(MK),int'(!MK),!MK, 31};
    tbl[27] = '{0,0, 0,0, 1,0,0, int'(MK),int'(!MK),!MK, 31};

    for (int i = 0; i < 28; i++) begin
      @(posedge clk); #1;
      rst = tbl[i].rst; ins_valid = tbl[i].iv; ins = tbl[i].d; outs_ready = tbl[i].ordy;
      @(negedge clk); #1;
      chk("tbl_ins_ready", i, ins_ready, tbl[i].e_rdy);
      chk("tbl_outs_valid", i, outs_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) chk("tbl_outs_match", i, outs_match, tbl[i].e_om);
      chk("tbl_match_count", i, match_count, tbl[i].e_mc);
      chk("tbl_mismatch_count", i, mismatch_count, tbl[i].e_mmc);
      chk("tbl_err", i, err, tbl[i].e_err);
      chk("tbl_last_value", i, last_value, tbl[i].e_last);
    end

    // random traffic with occasional resets; the scoreboard checks each cycle
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      rst        = ($urandom_range(0, 59) == 0);
      ins_valid  = $urandom_range(0, 1);
      ins        = ($urandom_range(0, 2) == 0) ? EXP_C : DW'($urandom_range(0, 63));
      outs_ready = ($urandom_range(0, 3) != 0);
    end

    // bounded drain
    @(posedge clk); #1;
    rst = 0; ins_valid = 0; outs_ready = 1;
    begin
      int k = 0;
      while (outs_valid && k < 10) begin
        @(negedge clk); #1;
        k++;
      end
    end
    chk("drain_empty", 0, outs_valid, 0);

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
